// File: rtl/perf_event_counter_bank.sv
// Event-counter bank: one counter per event strobe plus a cycle counter,
// gated by an IDLE/RUN/FROZEN controller, with sticky overflow and a registered read port.
module perf_event_counter_bank #(
    parameter int NUM_EVENTS = 6,
    parameter int CNT_WIDTH  = 32,
    parameter int SATURATE   = 0,
    parameter int SEL_WIDTH  = $clog2(NUM_EVENTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic                  halt,
    input  logic                  clear,
    input  logic [SEL_WIDTH-1:0]  rd_sel,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic [NUM_EVENTS:0]   overflow,
    output logic                  frozen
);

    localparam int NUM_CTRS = NUM_EVENTS + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FROZEN
    } bankState_t;

    bankState_t state;
    bankState_t nextState;

    logic [CNT_WIDTH-1:0] counts     [NUM_CTRS];
    logic [CNT_WIDTH-1:0] countsNext [NUM_CTRS];
    logic [NUM_EVENTS:0]  overflowNext;
    logic [NUM_EVENTS:0]  incVec;
    logic [CNT_WIDTH-1:0] rdNext;

    always_comb begin
        nextState = state;
        if (clear) begin
            nextState = halt ? FROZEN : (enable ? RUN : IDLE);
        end else begin
            case (state)
                IDLE: begin
                    if (halt) begin
                        nextState = FROZEN;
                    end else if (enable) begin
                        nextState = RUN;
                    end
                end
                RUN: begin
                    if (halt) begin
                        nextState = FROZEN;
                    end else if (!enable) begin
                        nextState = IDLE;
                    end
                end
                FROZEN:  nextState = FROZEN;
                default: nextState = IDLE;
            endcase
        end
    end

    // Counting happens only on edges where the bank is already in RUN, so
    // the halt edge still counts and a clear edge drops its increments.
    always_comb begin
        incVec = '0;
        if (state == RUN && !clear) begin
            incVec = {1'b1, event_in};
        end
    end

    always_comb begin
        overflowNext = overflow;
        for (int unsigned i = 0; i < NUM_CTRS; i++) begin
            countsNext[i] = counts[i];
            if (clear) begin
                countsNext[i]   = '0;
                overflowNext[i] = 1'b0;
            end else if (incVec[i]) begin
                if (&counts[i]) begin
                    overflowNext[i] = 1'b1;
                    countsNext[i]   = (SATURATE != 0) ? counts[i] : '0;
                end else begin
                    countsNext[i] = counts[i] + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        rdNext = '0;
        for (int unsigned i = 0; i < NUM_CTRS; i++) begin
            if (rd_sel == SEL_WIDTH'(i)) begin
                rdNext = counts[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            overflow <= '0;
            rd_data  <= '0;
            frozen   <= 1'b0;
            for (int unsigned i = 0; i < NUM_CTRS; i++) begin
                counts[i] <= '0;
            end
        end else begin
            state    <= nextState;
            overflow <= overflowNext;
            rd_data  <= rdNext;
            frozen   <= (nextState == FROZEN);
            for (int unsigned i = 0; i < NUM_CTRS; i++) begin
                counts[i] <= countsNext[i];
            end
        end
    end

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Scoreboard bench: one 32-bit wrapping bank and two 8-bit banks (wrap/saturate)
// share the stimulus; expectations are queued with a due cycle and checked by a monitor.
module tb_perf_event_counter_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [5:0]  event_in;
    logic        halt;
    logic        clear;
    logic [2:0]  rd_sel;

    logic [31:0] rdMain;
    logic [6:0]  ovfMain;
    logic        frzMain;
    logic [7:0]  rd8w;
    logic [6:0]  ovf8w;
    logic        frz8w;
    logic [7:0]  rd8s;
    logic [6:0]  ovf8s;
    logic        frz8s;

    always #5 clk = ~clk;

    perf_event_counter_bank #(.NUM_EVENTS(6), .CNT_WIDTH(32), .SATURATE(0)) dutMain (
        .clk(clk), .rst(rst), .enable(enable), .event_in(event_in), .halt(halt),
        .clear(clear), .rd_sel(rd_sel), .rd_data(rdMain), .overflow(ovfMain), .frozen(frzMain)
    );

    perf_event_counter_bank #(.NUM_EVENTS(6), .CNT_WIDTH(8), .SATURATE(0)) dutWrap8 (
        .clk(clk), .rst(rst), .enable(enable), .event_in(event_in), .halt(halt),
        .clear(clear), .rd_sel(rd_sel), .rd_data(rd8w), .overflow(ovf8w), .frozen(frz8w)
    );

    perf_event_counter_bank #(.NUM_EVENTS(6), .CNT_WIDTH(8), .SATURATE(1)) dutSat8 (
        .clk(clk), .rst(rst), .enable(enable), .event_in(event_in), .halt(halt),
        .clear(clear), .rd_sel(rd_sel), .rd_data(rd8s), .overflow(ovf8s), .frozen(frz8s)
    );

    typedef struct {
        int unsigned due;
        int unsigned sig;
        logic [31:0] want;
        string       tag;
    } expT;

    expT         sb[$];
    int unsigned cyc = 0;
    int          vectors = 0;
    int          errors = 0;
    expT         monE;
    logic [31:0] monGot;

    always @(posedge clk) cyc <= cyc + 1;

    // 0 rd main, 1 ovf main, 2 frozen main, 3 rd wrap8, 4 ovf wrap8,
    // 5 rd sat8, 6 ovf sat8, 7 frozen wrap8, 8 frozen sat8
    function automatic logic [31:0] actual(int unsigned sig);
        case (sig)
            0: return rdMain;
            1: return {25'b0, ovfMain};
            2: return {31'b0, frzMain};
            3: return {24'b0, rd8w};
            4: return {25'b0, ovf8w};
            5: return {24'b0, rd8s};
            6: return {25'b0, ovf8s};
            7: return {31'b0, frz8w};
            8: return {31'b0, frz8s};
            default: return 32'hdead_beef;
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            monE   = sb.pop_front();
            monGot = actual(monE.sig);
            vectors++;
            if (monGot !== monE.want) begin
                errors++;
                $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                         monE.tag, monGot, monGot, monE.want, monE.want, cyc);
            end
        end
    end

    task automatic expectNext(int unsigned sig, logic [31:0] want, string tag);
        sb.push_back('{cyc + 1, sig, want, tag});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(logic en, logic [5:0] ev, logic hl, logic cl);
        enable   = en;
        event_in = ev;
        halt     = hl;
        clear    = cl;
    endtask

    task automatic readChk(logic [2:0] sel, logic [31:0] want, string tag);
        drive(1'b0, 6'b0, 1'b0, 1'b0);
        rd_sel = sel;
        expectNext(0, want, tag);
        tick();
    endtask

    task automatic read3(logic [2:0] sel, logic [31:0] wMain, logic [31:0] wWrap,
                         logic [31:0] wSat, string tag);
        drive(1'b0, 6'b0, 1'b0, 1'b0);
        rd_sel = sel;
        expectNext(0, wMain, {tag, " main"});
        expectNext(3, wWrap, {tag, " wrap8"});
        expectNext(5, wSat, {tag, " sat8"});
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rd_sel = 3'd0;
        drive(1'b0, 6'b0, 1'b0, 1'b0);
        tick();
        expectNext(0, 0, "rst rd_data");
        expectNext(1, 0, "rst overflow");
        expectNext(2, 0, "rst frozen");
        expectNext(4, 0, "rst overflow wrap8");
        tick();
        rst = 1'b0;

        // 1: ten single-event RUN cycles
        drive(1'b1, 6'b0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 10; i++) begin
            drive(i < 9, 6'b000001, 1'b0, 1'b0); tick();
        end
        readChk(3'd0, 10, "t1 ctr0");
        readChk(3'd6, 10, "t1 cycles");
        readChk(3'd1, 0, "t1 ctr1");

        // 2: all events for 5 RUN cycles, halt on the 5th, then frozen
        drive(1'b0, 6'b0, 1'b0, 1'b1); tick();
        drive(1'b1, 6'b0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 6'h3f, i == 4, 1'b0);
            if (i == 4) begin
                expectNext(2, 1, "t2 frozen");
                expectNext(7, 1, "t2 frozen wrap8");
                expectNext(8, 1, "t2 frozen sat8");
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'h3f, 1'b0, 1'b0); tick();
        end
        for (int s = 0; s < 7; s++) begin
            readChk(3'(s), 5, $sformatf("t2 sel%0d", s));
        end
        expectNext(2, 1, "t2 frozen held");
        readChk(3'd0, 5, "t2 ctr0 held");

        // 4: enable drop with events ignored while idle
        drive(1'b0, 6'b0, 1'b0, 1'b1);
        expectNext(2, 0, "t4 frozen cleared");
        tick();
        drive(1'b1, 6'b0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(i < 3, 6'b000001, 1'b0, 1'b0); tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 6'b000001, 1'b0, 1'b0); tick();
        end
        drive(1'b1, 6'b0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 2; i++) begin
            drive(i < 1, 6'b000001, 1'b0, 1'b0); tick();
        end
        readChk(3'd0, 6, "t4 ctr0");
        readChk(3'd6, 6, "t4 cycles");

        // 5: clear and halt together while counts are 7
        drive(1'b0, 6'b0, 1'b0, 1'b1); tick();
        drive(1'b1, 6'b0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 6'h3f, 1'b0, 1'b0); tick();
        end
        drive(1'b1, 6'h3f, 1'b1, 1'b1);
        rd_sel = 3'd6;
        expectNext(0, 7, "t5 pre-clear read");
        expectNext(2, 1, "t5 frozen");
        expectNext(1, 0, "t5 overflow");
        tick();
        readChk(3'd0, 0, "t5 ctr0");
        readChk(3'd5, 0, "t5 ctr5");
        readChk(3'd6, 0, "t5 cycles");

        // 3: 256 events on bit 2 into the 8-bit banks
        drive(1'b0, 6'b0, 1'b0, 1'b1); tick();
        drive(1'b1, 6'b0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 256; i++) begin
            drive(i < 255, 6'b000100, 1'b0, 1'b0);
            if (i == 254) begin
                expectNext(4, 0, "t3 wrap8 ovf at 255");
                expectNext(6, 0, "t3 sat8 ovf at 255");
            end
            tick();
        end
        read3(3'd2, 256, 0, 255, "t3 ctr2");
        expectNext(1, 0, "t3 ovf main");
        expectNext(4, 32'h44, "t3 ovf wrap8");
        expectNext(6, 32'h44, "t3 ovf sat8");
        read3(3'd6, 256, 0, 255, "t3 cycles");

        // 6: reset in the middle of RUN
        drive(1'b1, 6'b0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 6'b000001, 1'b0, 1'b0); tick();
        end
        drive(1'b1, 6'b0, 1'b0, 1'b0);
        rd_sel = 3'd0;
        expectNext(0, 20, "t6 count before rst");
        tick();
        rst = 1'b1;
        drive(1'b1, 6'b000001, 1'b0, 1'b0);
        expectNext(0, 0, "t6 rd after rst");
        expectNext(1, 0, "t6 ovf after rst");
        expectNext(2, 0, "t6 frozen after rst");
        expectNext(4, 0, "t6 ovf wrap8 after rst");
        expectNext(6, 0, "t6 ovf sat8 after rst");
        tick();
        rst = 1'b0;
        for (int s = 0; s < 8; s++) begin
            readChk(3'(s), 0, $sformatf("t6 sel%0d", s));
        end
        readChk(3'd6, 0, "t6 cycles still idle");

        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            $display("FAIL scoreboard drain: got %0d pending want 0", sb.size());
            errors += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
